// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - NEC IR shared types and unit constants
// Shared by the NEC transmitter, receiver and controller.
package ir_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD_MARK,
      S_LEAD_SPACE,
      S_BIT_MARK,
      S_BIT_SPACE,
      S_STOP_MARK,
      S_GAP
   } nec_tx_state_t;

   localparam int LEAD_MARK_U  = 16;
   localparam int LEAD_SPACE_U = 8;
   localparam int REP_SPACE_U  = 4;
   localparam int ZERO_SPACE_U = 1;
   localparam int ONE_SPACE_U  = 3;

   function automatic logic is_mark(input nec_tx_state_t st);
      return st inside {S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK};
   endfunction

endpackage

// File: rtl/ir_nec_transmitter_if.sv
// rtl/ir_nec_transmitter_if.sv - request/response handshake for the NEC transmitter
interface ir_nec_tx_if;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_repeat;
   logic [7:0] tx_addr;
   logic [7:0] tx_cmd;
   logic       tx_done;

   modport master (output tx_valid, tx_repeat, tx_addr, tx_cmd, input tx_ready, tx_done);
   modport slave  (input tx_valid, tx_repeat, tx_addr, tx_cmd, output tx_ready, tx_done);
endinterface

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - 50% duty IR carrier, reloadable to start high
// carrier is the phase for the next cycle, so a registered consumer sees it aligned.
module ir_carrier_gen #(
   parameter int CARRIER_HALF = 658
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic carrier
);

   localparam int CW = $clog2(CARRIER_HALF + 1);

   logic [CW-1:0] cnt;
   logic          phase;
   logic          half_end;

   assign half_end = (cnt == CW'(CARRIER_HALF - 1));
   assign carrier  = restart ? 1'b1 : (half_end ? ~phase : phase);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         phase <= carrier;
         cnt   <= (restart || half_end) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/ir_nec_transmitter.sv
// rtl/ir_nec_transmitter.sv - NEC IR frame encoder with 38 kHz modulated LED output
// Envelope and LED outputs are registered from the next state, so they line up with the state.
module ir_nec_transmitter
   import ir_pkg::*;
#(
   parameter int UNIT_CYCLES  = 28125,
   parameter int CARRIER_HALF = 658,
   parameter int GAP_UNITS    = 72
) (
   input  logic         clk,
   input  logic         rst_n,
   ir_nec_tx_if.slave   tx,
   output logic         ir_env,
   output logic         ir_out
);

   localparam int UC_W  = $clog2(UNIT_CYCLES + 1);
   localparam int IDX_W = $clog2(((GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U) + 1);

   nec_tx_state_t state, state_next;
   logic [UC_W-1:0]  unit_cnt;
   logic [IDX_W-1:0] unit_idx;
   logic [IDX_W-1:0] phase_len;
   logic [4:0]       bit_idx;
   logic [31:0]      shreg;
   logic             rep_q;
   logic             unit_last, phase_end, accept;
   logic             env_next, restart, carrier;

   always_comb begin
      phase_len = IDX_W'(1);
      case (state)
         S_LEAD_MARK:  phase_len = IDX_W'(LEAD_MARK_U);
         S_LEAD_SPACE: phase_len = rep_q ? IDX_W'(REP_SPACE_U) : IDX_W'(LEAD_SPACE_U);
         S_BIT_SPACE:  phase_len = shreg[0] ? IDX_W'(ONE_SPACE_U) : IDX_W'(ZERO_SPACE_U);
         S_GAP:        phase_len = IDX_W'(GAP_UNITS);
         default:      phase_len = IDX_W'(1);
      endcase
   end

   assign unit_last = (unit_cnt == UC_W'(UNIT_CYCLES - 1));
   assign phase_end = unit_last && (unit_idx == phase_len - IDX_W'(1));
   assign accept    = (state == S_IDLE) && tx.tx_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:       if (tx.tx_valid) state_next = S_LEAD_MARK;
         S_LEAD_MARK:  if (phase_end) state_next = S_LEAD_SPACE;
         S_LEAD_SPACE: if (phase_end) state_next = rep_q ? S_STOP_MARK : S_BIT_MARK;
         S_BIT_MARK:   if (phase_end) state_next = S_BIT_SPACE;
         S_BIT_SPACE:  if (phase_end) state_next = (bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
         S_STOP_MARK:  if (phase_end) state_next = S_GAP;
         S_GAP:        if (phase_end) state_next = S_IDLE;
         default:      state_next = S_IDLE;
      endcase
   end

   // Marks are never adjacent, so any entry into a mark reloads the carrier.
   always_comb begin
      tx.tx_ready = (state == S_IDLE);
      tx.tx_done  = (state == S_STOP_MARK) && phase_end;
      env_next    = is_mark(state_next);
      restart     = env_next && !is_mark(state);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_cnt <= '0;
         unit_idx <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rep_q    <= 1'b0;
         ir_env   <= 1'b0;
         ir_out   <= 1'b0;
      end else begin
         if (state == S_IDLE || phase_end) begin
            unit_cnt <= '0;
            unit_idx <= '0;
         end else if (unit_last) begin
            unit_cnt <= '0;
            unit_idx <= unit_idx + IDX_W'(1);
         end else begin
            unit_cnt <= unit_cnt + UC_W'(1);
         end

         if (accept) begin
            shreg   <= {~tx.tx_cmd, tx.tx_cmd, ~tx.tx_addr, tx.tx_addr};
            rep_q   <= tx.tx_repeat;
            bit_idx <= '0;
         end else if (state == S_BIT_SPACE && phase_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 5'd1;
         end

         ir_env <= env_next;
         ir_out <= env_next & carrier;
      end
   end

   ir_carrier_gen #(
      .CARRIER_HALF(CARRIER_HALF)
   ) u_carrier (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .carrier (carrier)
   );

endmodule
